// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions used by the data-memory path.
// Provides the memory port count, the port-ID type, the IF/LSU port constants,
// the memory data width and the arbiter lock-state encoding.
package riscv_cpu_pkg;

  localparam int unsigned NUM_MEM_PORTS  = 2;
  localparam int unsigned MEM_DATA_WIDTH = 32;

  typedef logic [0:0] mem_port_id_t;

  localparam mem_port_id_t MEM_PORT_IF  = 1'b0;
  localparam mem_port_id_t MEM_PORT_LSU = 1'b1;

  // Arbiter lock: which port (if any) owns the memory request until granted.
  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_IF   = 2'd1,
    LOCK_LSU  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/mem_id_fifo.sv
// In-order FIFO of memory port IDs.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, push_id_i write an ID (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   head_o            ID at the head of the FIFO
//   full_o, empty_o   occupancy flags from registered state
//   count_o           occupancy, 0..DEPTH (DEPTH legal range 1..4)
module mem_id_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  mem_port_id_t push_id_i,
  input  logic         pop_i,
  output mem_port_id_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [2:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_port_id_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [2:0]      count_q;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full_o  = (count_q == 3'(DEPTH));
  assign empty_o = (count_q == 3'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between instruction fetch (port 0) and
// the load/store unit (port 1) with round-robin arbitration. The selected
// request is locked until granted; granted port IDs are queued in order so
// each memory response is routed back to its owner.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/gnt_o/rvalid_o   per-port handshake (bit n = port n)
//   addr_i/we_i/wdata_i    per-port request payload, port n at slice n
//   rdata_o                response data broadcast to both ports
//   data_*                 memory-side req/gnt/rvalid interface
//   outstanding_o          responses still owed by memory
//   err_o                  sticky: memory response with nothing outstanding
module data_mem_arbiter
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_WIDTH      = MEM_DATA_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_MEM_PORTS-1:0]           req_i,
  output logic [NUM_MEM_PORTS-1:0]           gnt_o,
  output logic [NUM_MEM_PORTS-1:0]           rvalid_o,
  input  logic [NUM_MEM_PORTS*32-1:0]        addr_i,
  input  logic [NUM_MEM_PORTS-1:0]           we_i,
  input  logic [NUM_MEM_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic                               data_req_o,
  input  logic                               data_gnt_i,
  input  logic                               data_rvalid_i,
  output logic [31:0]                        data_addr_o,
  output logic                               data_we_o,
  output logic [DATA_WIDTH-1:0]              data_wdata_o,
  input  logic [DATA_WIDTH-1:0]              data_rdata_i,
  output logic [2:0]                         outstanding_o,
  output logic                               err_o
);

  lock_state_e  lock_q;
  lock_state_e  lock_d;
  mem_port_id_t prio_q;
  mem_port_id_t sel;
  mem_port_id_t head_id;
  logic         sel_valid;
  logic         lock_hold;
  logic         fifo_full;
  logic         fifo_empty;
  logic         grant;
  logic         pop;
  logic         err_q;

  // Selection. A lock whose port has dropped its request is ignored so a
  // misbehaving requester cannot wedge the arbiter.
  always_comb begin
    lock_hold = 1'b0;
    sel_valid = 1'b0;
    sel       = MEM_PORT_IF;
    if (lock_q == LOCK_IF && req_i[MEM_PORT_IF]) begin
      lock_hold = 1'b1;
      sel_valid = 1'b1;
      sel       = MEM_PORT_IF;
    end else if (lock_q == LOCK_LSU && req_i[MEM_PORT_LSU]) begin
      lock_hold = 1'b1;
      sel_valid = 1'b1;
      sel       = MEM_PORT_LSU;
    end else begin
      sel_valid = |req_i;
      if (req_i == 2'b11) begin
        sel = prio_q;
      end else if (req_i[MEM_PORT_LSU]) begin
        sel = MEM_PORT_LSU;
      end else begin
        sel = MEM_PORT_IF;
      end
    end
  end

  // Full is taken from registered occupancy: no rvalid -> req path.
  assign data_req_o = rst_ni && sel_valid && !fifo_full;
  assign grant      = data_req_o && data_gnt_i;
  assign gnt_o      = grant ? (2'b01 << sel) : '0;

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_wdata_o = '0;
    if (sel_valid) begin
      if (sel == MEM_PORT_LSU) begin
        data_addr_o  = addr_i[63:32];
        data_we_o    = we_i[1];
        data_wdata_o = wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
      end else begin
        data_addr_o  = addr_i[31:0];
        data_we_o    = we_i[0];
        data_wdata_o = wdata_i[DATA_WIDTH-1:0];
      end
    end
  end

  // Lock next state.
  always_comb begin
    lock_d = LOCK_NONE;
    if (grant) begin
      lock_d = LOCK_NONE;
    end else if (data_req_o) begin
      lock_d = (sel == MEM_PORT_LSU) ? LOCK_LSU : LOCK_IF;
    end else if (lock_hold) begin
      lock_d = lock_q;
    end
  end

  assign pop      = data_rvalid_i && !fifo_empty;
  assign rvalid_o = pop ? (2'b01 << head_id) : '0;
  assign rdata_o  = data_rdata_i;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= LOCK_NONE;
      prio_q <= MEM_PORT_IF;
      err_q  <= 1'b0;
    end else begin
      lock_q <= lock_d;
      if (grant) begin
        prio_q <= ~sel;
      end
      if (data_rvalid_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  mem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (sel),
    .pop_i     (pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding_o)
  );

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [63:0] addr;
  logic [1:0]  we;
  logic [63:0] wdata;
  logic [31:0] rdata;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_addr;
  logic        data_we;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic [2:0]  outstanding;
  logic        err;

  int checks   = 0;
  int failures = 0;

  data_mem_arbiter #(
    .MAX_OUTSTANDING (2),
    .DATA_WIDTH      (32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .addr_i        (addr),
    .we_i          (we),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .data_req_o    (data_req),
    .data_gnt_i    (data_gnt),
    .data_rvalid_i (data_rvalid),
    .data_addr_o   (data_addr),
    .data_we_o     (data_we),
    .data_wdata_o  (data_wdata),
    .data_rdata_i  (data_rdata),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    req         = 2'b11;
    addr        = 64'h0000_0300_0000_0200;
    we          = 2'b00;
    wdata       = '0;
    data_gnt    = 1'b1;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    #2;
    check("rst_gnt", gnt, 2'b00);
    check("rst_data_req", data_req, 1'b0);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_err", err, 1'b0);
    req      = 2'b00;
    addr     = '0;
    data_gnt = 1'b0;
    #1;
    check("rst_addr", data_addr, 32'h0);
    check("rst_we", data_we, 1'b0);
    check("rst_wdata", data_wdata, 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Single LSU read, response two cycles after grant
    req           = 2'b10;
    addr[63:32]   = 32'h100;
    data_gnt      = 1'b1;
    #4;
    check("t1_gnt", gnt, 2'b10);
    check("t1_req", data_req, 1'b1);
    check("t1_addr", data_addr, 32'h100);
    check("t1_we", data_we, 1'b0);
    check("t1_occ0", outstanding, 3'd0);
    next_cycle();
    req      = 2'b00;
    data_gnt = 1'b0;
    addr     = '0;
    #4;
    check("t1_occ1", outstanding, 3'd1);
    check("t1_rv_early", rvalid, 2'b00);
    next_cycle();
    data_rvalid = 1'b1;
    data_rdata  = 32'hDEADBEEF;
    #4;
    check("t1_rvalid", rvalid, 2'b10);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    next_cycle();
    data_rvalid = 1'b0;
    #4;
    check("t1_occ_end", outstanding, 3'd0);
    check("t1_rv_end", rvalid, 2'b00);

    // Round-robin under continuous requests
    next_cycle();
    req      = 2'b11;
    addr     = 64'h0000_0300_0000_0200;
    data_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        next_cycle();
        data_rvalid = 1'b1;
      end
      #4;
      check("t2_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_addr", data_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
      check("t2_rvalid", rvalid, (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10));
      check("t2_occ", outstanding, (i == 0) ? 3'd0 : 3'd1);
    end
    next_cycle();
    req      = 2'b00;
    data_gnt = 1'b0;
    #4;
    check("t2_last_rv", rvalid, 2'b10);
    check("t2_last_gnt", gnt, 2'b00);
    next_cycle();
    data_rvalid = 1'b0;
    #4;
    check("t2_occ_end", outstanding, 3'd0);

    // Lock hold: priority is first moved to port 1 so only the lock keeps port 0
    next_cycle();
    req      = 2'b01;
    addr     = 64'h0000_0080_0000_0040;
    we       = 2'b01;
    wdata    = 64'h0000_5678_0000_1234;
    data_gnt = 1'b1;
    #4;
    check("t3_setup_gnt", gnt, 2'b01);
    next_cycle();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    #4;
    check("t3_setup_rv", rvalid, 2'b01);
    check("t3_req", data_req, 1'b1);
    check("t3_addr0", data_addr, 32'h40);
    check("t3_we", data_we, 1'b1);
    check("t3_wdata", data_wdata, 32'h1234);
    check("t3_gnt0", gnt, 2'b00);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      data_rvalid = 1'b0;
      req         = 2'b11;
      #4;
      check("t3_addr_held", data_addr, 32'h40);
      check("t3_gnt_held", gnt, 2'b00);
    end
    next_cycle();
    data_gnt = 1'b1;
    #4;
    check("t3_gnt_p0", gnt, 2'b01);
    check("t3_addr_p0", data_addr, 32'h40);
    next_cycle();
    #4;
    check("t3_gnt_p1", gnt, 2'b10);
    check("t3_addr_p1", data_addr, 32'h80);
    check("t3_occ", outstanding, 3'd1);

    // FIFO full blocks requests; a same-cycle pop does not unblock
    next_cycle();
    #4;
    check("t4_occ_full", outstanding, 3'd2);
    check("t4_req_blocked", data_req, 1'b0);
    check("t4_gnt_blocked", gnt, 2'b00);
    next_cycle();
    data_rvalid = 1'b1;
    #4;
    check("t4_pop_rv", rvalid, 2'b01);
    check("t4_req_same_cycle", data_req, 1'b0);
    next_cycle();
    data_rvalid = 1'b0;
    #4;
    check("t4_occ_after_pop", outstanding, 3'd1);
    check("t4_req_again", data_req, 1'b1);
    check("t4_gnt_again", gnt, 2'b01);
    next_cycle();
    data_rvalid = 1'b1;
    #4;
    check("t4_pop2_rv", rvalid, 2'b10);
    check("t4_req_blocked2", data_req, 1'b0);
    next_cycle();
    data_rvalid = 1'b0;
    data_gnt    = 1'b0;
    #4;
    check("t4_lock_p1_addr", data_addr, 32'h80);
    check("t4_lock_p1_req", data_req, 1'b1);

    // Reset with an outstanding entry and port 1 locked
    next_cycle();
    #4;
    check("t6_locked_addr", data_addr, 32'h80);
    rst_n    = 1'b0;
    data_gnt = 1'b1;
    #1;
    check("t6_rst_occ", outstanding, 3'd0);
    check("t6_rst_req", data_req, 1'b0);
    check("t6_rst_gnt", gnt, 2'b00);
    next_cycle();
    rst_n = 1'b1;
    #4;
    check("t6_post_gnt", gnt, 2'b01);
    check("t6_post_addr", data_addr, 32'h40);

    // Spurious response raises the sticky error
    next_cycle();
    req         = 2'b00;
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    #4;
    check("t5_drain_rv", rvalid, 2'b01);
    check("t5_err_clear", err, 1'b0);
    next_cycle();
    #4;
    check("t5_spurious_rv", rvalid, 2'b00);
    check("t5_occ_empty", outstanding, 3'd0);
    next_cycle();
    data_rvalid = 1'b0;
    #4;
    check("t5_err_set", err, 1'b1);
    next_cycle();
    #4;
    check("t5_err_held", err, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_err_rst", err, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #4;
    check("t5_err_after_rst", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
